fifo_flags: RTL
===============

Name: fifo_flags

Overview:
- Synchronous single-clock FIFO with status-flag generation. One instance is built per channel; the design uses five.
- Each instance's almost_full / full / almost_empty / empty outputs drive the flow-control block's aff<n> / ff<n> / aef<n> / ef<n> inputs.
- The flow-control block's continuar bits drive this FIFO's rd_en; gating is done outside this block.
- Flags are mutually exclusive by construction, so flow control can treat them as a one-hot occupancy class.

Parameters:
- DATA_WIDTH, 6, payload width in bits.
- ADDR_WIDTH, 3, pointer width. Depth DEPTH = 2**ADDR_WIDTH (default 8).
- AF_THRESH, 6, occupancy at or above which almost_full asserts. Legal range 1..DEPTH-1.
- AE_THRESH, 2, occupancy at or below which almost_empty asserts (when not empty). Legal range 1..AF_THRESH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request, sampled on the clk rising edge.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request, sampled on the clk rising edge.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- full  output  1  count == DEPTH.
- almost_full  output  1  AF_THRESH <= count < DEPTH.
- empty  output  1  count == 0.
- almost_empty  output  1  0 < count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- fifo_error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Single clock domain; one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (takes priority over wr_en/rd_en, including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, fifo_error=0.
  - Flags after reset: empty=1, almost_empty=0, almost_full=0, full=0.
  - Memory contents are don't-care and are not cleared.
- Storage: DEPTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Accepted write (wr_en & (!full | rd_accept)):
  - mem[wr_ptr] <= data_in; wr_ptr += 1.
- Accepted read (rd_en & !empty), called rd_accept:
  - data_out <= mem[rd_ptr]; rd_ptr += 1; valid_out <= 1.
- No accepted read: valid_out <= 0; data_out holds its last value.
- Read latency: 1 cycle. Data is visible in the cycle after the rd_en edge. There is no fall-through: a word written at edge N is readable at the earliest via rd_en sampled at edge N+1.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Flags are combinational decodes of the registered count, so they are glitch-free with respect to inputs. Exactly one of {empty, almost_empty, almost_full, full} may be high, or none (mid occupancy).
- Simultaneous wr_en & rd_en:
  - When full: both are accepted (read frees the slot); count stays DEPTH; no error.
  - When empty: the write is accepted; the read is rejected; count becomes 1; fifo_error is set.
- Overflow: wr_en & full & !rd_en drops the write; pointers and count are unchanged; fifo_error <= 1.
- Underflow: rd_en & empty rejects the read; valid_out <= 0; fifo_error <= 1.
- fifo_error is sticky until reset.

Test Plan:
- Reset, then idle 2 cycles -> empty=1, count=0, valid_out=0, data_out=0, fifo_error=0, all other flags 0.
- Write 1,2,3,4,5,6,7,8 on 8 consecutive cycles -> after write 1 almost_empty=1; count 3..5 no flag; after write 6 almost_full=1; after write 8 full=1, count=8.
- From full, 8 consecutive reads -> data_out 1..8 each one cycle after its rd_en edge with valid_out=1; flags walk full -> almost_full -> none -> almost_empty -> empty; fifo_error=0.
- From full, write 9 with rd_en=1 -> data_out=1, count stays 8, full stays 1, no error. Next wr-only cycle -> write dropped, fifo_error=1, count=8.
- Wrap-around: 5 writes, 5 reads, 6 writes, 6 reads -> read order equals write order across the pointer wrap; ends empty=1.
- Empty FIFO, wr_en=rd_en=1 -> count=1, valid_out=0, fifo_error=1. Assert reset with count=4 -> next edge count=0, empty=1, fifo_error=0.

Source files
------------

// File: rtl/fifo_flags.sv
// fifo_flags
// Synchronous single-clock FIFO with occupancy flag generation. One instance
// serves one flow-control channel. The four flags are one-hot (or all low at
// mid occupancy), so the flow-control block can treat them as an occupancy class.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   wr_en        write request
//   data_in      write data
//   rd_en        read request
//   data_out     registered read data (one-cycle latency)
//   valid_out    data_out holds a word popped on the previous edge
//   full         count == DEPTH
//   almost_full  AF_THRESH <= count < DEPTH
//   empty        count == 0
//   almost_empty 0 < count <= AE_THRESH
//   count        current occupancy, 0..DEPTH
//   fifo_error   sticky overflow/underflow indicator, cleared only by reset
module fifo_flags #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;

  // Accept decisions. A read frees a slot in the same edge, so a write into a
  // full FIFO is still taken when a read is accepted alongside it. The read
  // side only looks at the registered count, so a word written this edge can
  // never be read back through the same edge (no fall-through).
  always_comb begin
    rd_accept = rd_en & ~empty;
    wr_accept = wr_en & (~full | rd_accept);
  end

  // Flags are pure decodes of the registered count, so they never glitch on
  // input changes. almost_full excludes full and almost_empty excludes empty,
  // which keeps the four flags mutually exclusive.
  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_full  = (count >= AF_C) && !full;
    almost_empty = (count <= AE_C) && !empty;
  end

  // Storage array. Contents are never cleared; only the pointers define
  // which entries are live, so reset does not need to touch it.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read port and error tracking. Reset wins over any
  // request. Pointers wrap naturally at DEPTH. The error bit records any
  // dropped write or rejected read and stays set until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      valid_out <= rd_accept;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if ((wr_en && !wr_accept) || (rd_en && empty)) begin
        fifo_error <= 1'b1;
      end
    end
  end

endmodule
